branch_resolve_unit: RTL and testbench

//  Execute-side partner of the BHT/BTB controller. Carries each fetch-time prediction down the

---
 rtl/branch_resolve_unit.sv | 191 +++++++++++++++++++
 tb/tb_branch_resolve_unit.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
// Execute-side branch resolution: carries each fetch-time prediction to execute, checks it
// against the real outcome, drives the predictor update port and issues redirects.
module branch_resolve_unit #(
    parameter int COUNTER_BITS = 2,
    parameter int STAGES       = 2,
    parameter int STAT_BITS    = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    stall,
    input  logic                    fetch_valid,
    input  logic [31:0]             fetch_pc,
    input  logic                    fetch_hit,
    input  logic                    fetch_pred_taken,
    input  logic [31:0]             fetch_pred_target,
    input  logic [COUNTER_BITS-1:0] fetch_counter,
    input  logic                    ex_valid,
    input  logic                    ex_is_branch,
    input  logic                    ex_taken,
    input  logic [31:0]             ex_target,
    output logic                    upd_is_branch,
    output logic [31:0]             upd_pc_fetch,
    output logic [31:0]             upd_pc_target,
    output logic [COUNTER_BITS-1:0] upd_prev_counter,
    output logic                    upd_prev_valid,
    output logic                    upd_increment,
    output logic                    redirect_valid,
    output logic [31:0]             redirect_pc,
    output logic [STAT_BITS-1:0]    branch_count,
    output logic [STAT_BITS-1:0]    mispredict_count
);

    typedef enum logic [0:0] {
        ST_RUN      = 1'b0,
        ST_REDIRECT = 1'b1
    } state_e;

    typedef struct packed {
        logic                    v;
        logic [31:0]             pc;
        logic                    hit;
        logic                    pred_taken;
        logic [31:0]             pred_target;
        logic [COUNTER_BITS-1:0] counter;
    } entry_t;

    localparam int                     LAST       = STAGES - 1;
    localparam entry_t                 ENTRY_NONE = {$bits(entry_t){1'b0}};
    localparam logic [STAT_BITS-1:0]   STAT_MAX   = {STAT_BITS{1'b1}};
    localparam logic [STAT_BITS-1:0]   STAT_ONE   = {{(STAT_BITS-1){1'b0}}, 1'b1};
    // A branch the predictor missed is written back as weakly not-taken.
    localparam logic [COUNTER_BITS-1:0] WEAK_NT   = {{(COUNTER_BITS-1){1'b0}}, 1'b1};

    state_e                  state_q;
    entry_t                  pipe_q [STAGES];
    entry_t                  exe_s;
    entry_t                  fetch_entry_s;
    logic                    eval_s;
    logic                    mispred_s;

    logic                    upd_is_branch_q;
    logic [31:0]             upd_pc_fetch_q, upd_pc_fetch_d;
    logic [31:0]             upd_pc_target_q, upd_pc_target_d;
    logic [COUNTER_BITS-1:0] upd_prev_counter_q, upd_prev_counter_d;
    logic                    upd_prev_valid_q, upd_prev_valid_d;
    logic                    upd_increment_q, upd_increment_d;
    logic                    redirect_valid_q;
    logic [31:0]             redirect_pc_q, redirect_pc_d;
    logic [STAT_BITS-1:0]    branch_count_q, branch_count_d;
    logic [STAT_BITS-1:0]    mispredict_count_q, mispredict_count_d;

    // Resolve the oldest in-flight prediction and form the next update/redirect values.
    always_comb begin
        exe_s         = pipe_q[LAST];
        fetch_entry_s = {fetch_valid, fetch_pc, fetch_hit, fetch_pred_taken,
                         fetch_pred_target, fetch_counter};
        eval_s        = !stall && (state_q == ST_RUN) && ex_valid && exe_s.v && ex_is_branch;
        mispred_s     = eval_s && ((exe_s.pred_taken != ex_taken) ||
                        (exe_s.pred_taken && ex_taken && (exe_s.pred_target != ex_target)));

        upd_pc_fetch_d     = upd_pc_fetch_q;
        upd_pc_target_d    = upd_pc_target_q;
        upd_prev_counter_d = upd_prev_counter_q;
        upd_prev_valid_d   = upd_prev_valid_q;
        upd_increment_d    = upd_increment_q;
        redirect_pc_d      = redirect_pc_q;
        branch_count_d     = branch_count_q;
        mispredict_count_d = mispredict_count_q;

        if (eval_s) begin
            upd_pc_fetch_d     = exe_s.pc;
            upd_pc_target_d    = ex_target;
            upd_prev_counter_d = exe_s.hit ? exe_s.counter : WEAK_NT;
            upd_prev_valid_d   = exe_s.hit;
            upd_increment_d    = ex_taken;
            if (branch_count_q != STAT_MAX) begin
                branch_count_d = branch_count_q + STAT_ONE;
            end else begin
                branch_count_d = branch_count_q;
            end
        end else begin
            upd_pc_fetch_d = upd_pc_fetch_q;
        end

        if (mispred_s) begin
            redirect_pc_d = ex_taken ? ex_target : (exe_s.pc + 32'd4);
            if (mispredict_count_q != STAT_MAX) begin
                mispredict_count_d = mispredict_count_q + STAT_ONE;
            end else begin
                mispredict_count_d = mispredict_count_q;
            end
        end else begin
            redirect_pc_d = redirect_pc_q;
        end
    end

    // FSM, prediction pipe and registered update/redirect outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q            <= ST_RUN;
            for (int i = 0; i < STAGES; i++) begin
                pipe_q[i] <= ENTRY_NONE;
            end
            upd_is_branch_q    <= 1'b0;
            upd_pc_fetch_q     <= 32'd0;
            upd_pc_target_q    <= 32'd0;
            upd_prev_counter_q <= {COUNTER_BITS{1'b0}};
            upd_prev_valid_q   <= 1'b0;
            upd_increment_q    <= 1'b0;
            redirect_valid_q   <= 1'b0;
            redirect_pc_q      <= 32'd0;
            branch_count_q     <= {STAT_BITS{1'b0}};
            mispredict_count_q <= {STAT_BITS{1'b0}};
        end else begin
            upd_is_branch_q    <= eval_s;
            redirect_valid_q   <= mispred_s;
            upd_pc_fetch_q     <= upd_pc_fetch_d;
            upd_pc_target_q    <= upd_pc_target_d;
            upd_prev_counter_q <= upd_prev_counter_d;
            upd_prev_valid_q   <= upd_prev_valid_d;
            upd_increment_q    <= upd_increment_d;
            redirect_pc_q      <= redirect_pc_d;
            branch_count_q     <= branch_count_d;
            mispredict_count_q <= mispredict_count_d;

            case (state_q)
                ST_RUN: begin
                    if (stall) begin
                        state_q <= ST_RUN;
                    end else if (mispred_s) begin
                        state_q <= ST_REDIRECT;
                        for (int i = 0; i < STAGES; i++) begin
                            pipe_q[i].v <= 1'b0;
                        end
                    end else begin
                        state_q   <= ST_RUN;
                        pipe_q[0] <= fetch_entry_s;
                        for (int i = 1; i < STAGES; i++) begin
                            pipe_q[i] <= pipe_q[i-1];
                        end
                    end
                end
                // The fetch made on the redirect edge is wrong-path; keep the pipe empty.
                ST_REDIRECT: begin
                    state_q <= ST_RUN;
                    for (int i = 0; i < STAGES; i++) begin
                        pipe_q[i].v <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_RUN;
                    for (int i = 0; i < STAGES; i++) begin
                        pipe_q[i].v <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign upd_is_branch    = upd_is_branch_q;
    assign upd_pc_fetch     = upd_pc_fetch_q;
    assign upd_pc_target    = upd_pc_target_q;
    assign upd_prev_counter = upd_prev_counter_q;
    assign upd_prev_valid   = upd_prev_valid_q;
    assign upd_increment    = upd_increment_q;
    assign redirect_valid   = redirect_valid_q;
    assign redirect_pc      = redirect_pc_q;
    assign branch_count     = branch_count_q;
    assign mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: directed scenarios plus random traffic, all outputs compared
// every cycle against a queue-based model of the in-flight predictions.
module tb_branch_resolve_unit;

    localparam int CB = 2;
    localparam int ST = 2;
    localparam int SB = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          stall = 1'b0, fetch_valid = 1'b0, fetch_hit = 1'b0, fetch_pred_taken = 1'b0;
    logic [31:0]   fetch_pc = 32'd0, fetch_pred_target = 32'd0, ex_target = 32'd0;
    logic [CB-1:0] fetch_counter = 2'd0;
    logic          ex_valid = 1'b0, ex_is_branch = 1'b0, ex_taken = 1'b0;
    logic          upd_is_branch, upd_prev_valid, upd_increment, redirect_valid;
    logic [31:0]   upd_pc_fetch, upd_pc_target, redirect_pc;
    logic [CB-1:0] upd_prev_counter;
    logic [SB-1:0] branch_count, mispredict_count;

    always #5 clk = ~clk;

    branch_resolve_unit #(.COUNTER_BITS(CB), .STAGES(ST), .STAT_BITS(SB)) dut (
        .clk(clk), .reset_n(reset_n), .stall(stall),
        .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .fetch_hit(fetch_hit),
        .fetch_pred_taken(fetch_pred_taken), .fetch_pred_target(fetch_pred_target),
        .fetch_counter(fetch_counter), .ex_valid(ex_valid), .ex_is_branch(ex_is_branch),
        .ex_taken(ex_taken), .ex_target(ex_target),
        .upd_is_branch(upd_is_branch), .upd_pc_fetch(upd_pc_fetch),
        .upd_pc_target(upd_pc_target), .upd_prev_counter(upd_prev_counter),
        .upd_prev_valid(upd_prev_valid), .upd_increment(upd_increment),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .branch_count(branch_count), .mispredict_count(mispredict_count)
    );

    typedef struct {
        bit          v;
        bit [31:0]   pc;
        bit          hit;
        bit          pt;
        bit [31:0]   tgt;
        bit [CB-1:0] cnt;
    } rec_t;

    rec_t          flight[$];
    bit            m_redir;
    bit            e_ub, e_pv, e_inc, e_rv;
    bit [31:0]     e_pcf, e_pct, e_rpc;
    bit [CB-1:0]   e_pc;
    bit [SB-1:0]   e_bc, e_mc;
    int            n_tests = 0;
    int            n_fail = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic compare_all();
        check_eq("upd_is_branch", 32'(upd_is_branch), 32'(e_ub));
        check_eq("upd_pc_fetch", upd_pc_fetch, e_pcf);
        check_eq("upd_pc_target", upd_pc_target, e_pct);
        check_eq("upd_prev_counter", 32'(upd_prev_counter), 32'(e_pc));
        check_eq("upd_prev_valid", 32'(upd_prev_valid), 32'(e_pv));
        check_eq("upd_increment", 32'(upd_increment), 32'(e_inc));
        check_eq("redirect_valid", 32'(redirect_valid), 32'(e_rv));
        check_eq("redirect_pc", redirect_pc, e_rpc);
        check_eq("branch_count", 32'(branch_count), 32'(e_bc));
        check_eq("mispredict_count", 32'(mispredict_count), 32'(e_mc));
    endtask

    function automatic rec_t make_rec(bit v, bit [31:0] pc, bit hit, bit pt, bit [31:0] tgt,
                                      bit [CB-1:0] cnt);
        rec_t r;
        r.v = v; r.pc = pc; r.hit = hit; r.pt = pt; r.tgt = tgt; r.cnt = cnt;
        return r;
    endfunction

    function automatic void model_reset();
        flight.delete();
        for (int i = 0; i < ST; i++) flight.push_back(make_rec(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 2'd0));
        m_redir = 1'b0;
        e_ub = 1'b0; e_pv = 1'b0; e_inc = 1'b0; e_rv = 1'b0;
        e_pcf = 32'd0; e_pct = 32'd0; e_rpc = 32'd0; e_pc = 2'd0;
        e_bc = 4'd0; e_mc = 4'd0;
    endfunction

    function automatic void flush();
        for (int i = 0; i < flight.size(); i++) flight[i].v = 1'b0;
    endfunction

    // Predict the outputs after the coming edge from the inputs now applied.
    function automatic void model_step();
        rec_t e;
        bit   ev, mis;
        e = flight[0];
        e_ub = 1'b0;
        e_rv = 1'b0;
        if (m_redir) begin
            m_redir = 1'b0;
            flush();
        end else if (!stall) begin
            ev  = ex_valid && e.v && ex_is_branch;
            mis = ev && ((e.pt != ex_taken) || (e.pt && e.tgt != ex_target));
            if (ev) begin
                e_ub = 1'b1; e_pcf = e.pc; e_pct = ex_target; e_inc = ex_taken;
                e_pv = e.hit; e_pc = e.hit ? e.cnt : 2'b01;
                if (e_bc != 4'hF) e_bc++;
            end
            if (mis) begin
                e_rv = 1'b1;
                e_rpc = ex_taken ? ex_target : e.pc + 32'd4;
                if (e_mc != 4'hF) e_mc++;
                flush();
                m_redir = 1'b1;
            end else begin
                void'(flight.pop_front());
                flight.push_back(make_rec(fetch_valid, fetch_pc, fetch_hit, fetch_pred_taken,
                                          fetch_pred_target, fetch_counter));
            end
        end
    endfunction

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic drive(input bit s, input bit fv, input logic [31:0] pc, input bit hit,
                         input bit pt, input logic [31:0] tg, input logic [CB-1:0] cn,
                         input bit xv, input bit xb, input bit xt, input logic [31:0] xtg);
        stall = s; fetch_valid = fv; fetch_pc = pc; fetch_hit = hit; fetch_pred_taken = pt;
        fetch_pred_target = tg; fetch_counter = cn;
        ex_valid = xv; ex_is_branch = xb; ex_taken = xt; ex_target = xtg;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 2'd0, 1'b0, 1'b0, 1'b0, 32'd0);
    endtask

    task automatic rand_drive();
        drive($urandom_range(0, 5) == 0, $urandom_range(0, 3) != 0,
              32'($urandom_range(0, 255)) << 2, 1'($urandom), 1'($urandom),
              $urandom_range(0, 1) ? 32'h100 : 32'h104, 2'($urandom),
              $urandom_range(0, 4) != 0, $urandom_range(0, 4) != 0, 1'($urandom),
              $urandom_range(0, 1) ? 32'h100 : 32'h104);
    endtask

    // Asynchronous reset between edges; outputs must clear without a clock.
    task automatic do_reset();
        #2 reset_n = 1'b0;
        model_reset();
        #1 compare_all();
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        idle();
    endtask

    initial begin
        model_reset();
        idle();
        #1 compare_all();
        @(negedge clk);
        reset_n = 1'b1;

        // 1: predicted-taken hit resolves taken to the predicted target
        drive(0, 1, 32'h20, 1, 1, 32'h100, 2'b11, 0, 0, 0, 32'd0); tick();
        idle(); tick();
        drive(0, 0, 32'd0, 0, 0, 32'd0, 2'd0, 1, 1, 1, 32'h100); tick();
        check_eq("t1_upd", 32'(upd_is_branch), 32'd1);
        check_eq("t1_inc", 32'(upd_increment), 32'd1);
        check_eq("t1_ctr", 32'(upd_prev_counter), 32'd3);
        check_eq("t1_redir", 32'(redirect_valid), 32'd0);
        check_eq("t1_bcount", 32'(branch_count), 32'd1);

        // 2: predicted NT, resolved taken; two younger fetches are discarded
        drive(0, 1, 32'h40, 1, 0, 32'd0, 2'b01, 0, 0, 0, 32'd0); tick();
        drive(0, 1, 32'h44, 1, 0, 32'd0, 2'b01, 0, 0, 0, 32'd0); tick();
        drive(0, 1, 32'h48, 1, 0, 32'd0, 2'b01, 1, 1, 1, 32'h80); tick();
        check_eq("t2_redir", 32'(redirect_valid), 32'd1);
        check_eq("t2_rpc", redirect_pc, 32'h80);
        check_eq("t2_mcount", 32'(mispredict_count), 32'd1);
        drive(0, 1, 32'h4c, 1, 0, 32'd0, 2'b01, 1, 1, 0, 32'd0); tick();
        check_eq("t2_pulse_end", 32'(redirect_valid), 32'd0);
        check_eq("t2_discard1", 32'(upd_is_branch), 32'd0);
        drive(0, 1, 32'h80, 1, 0, 32'd0, 2'b01, 1, 1, 0, 32'd0); tick();
        check_eq("t2_discard2", 32'(upd_is_branch), 32'd0);

        // 3: predicted taken to the wrong target
        drive(0, 1, 32'h60, 1, 1, 32'h200, 2'b10, 0, 0, 0, 32'd0); tick();
        idle(); tick();
        drive(0, 0, 32'd0, 0, 0, 32'd0, 2'd0, 1, 1, 1, 32'h204); tick();
        check_eq("t3_redir", 32'(redirect_valid), 32'd1);
        check_eq("t3_rpc", redirect_pc, 32'h204);
        check_eq("t3_tgt", upd_pc_target, 32'h204);
        idle(); tick();

        // 4: predictor miss resolved not-taken
        drive(0, 1, 32'h10, 0, 0, 32'd0, 2'b11, 0, 0, 0, 32'd0); tick();
        idle(); tick();
        drive(0, 0, 32'd0, 0, 0, 32'd0, 2'd0, 1, 1, 0, 32'h999); tick();
        check_eq("t4_ctr", 32'(upd_prev_counter), 32'd1);
        check_eq("t4_pvalid", 32'(upd_prev_valid), 32'd0);
        check_eq("t4_inc", 32'(upd_increment), 32'd0);
        check_eq("t4_redir", 32'(redirect_valid), 32'd0);

        // 5: stall holds a mispredicting branch at execute for 3 cycles
        drive(0, 1, 32'h70, 1, 0, 32'd0, 2'b01, 0, 0, 0, 32'd0); tick();
        idle(); tick();
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 32'h90, 1, 1, 32'h104, 2'b11, 1, 1, 1, 32'h300); tick();
            check_eq("t5_stall_redir", 32'(redirect_valid), 32'd0);
        end
        drive(0, 0, 32'd0, 0, 0, 32'd0, 2'd0, 1, 1, 1, 32'h300); tick();
        check_eq("t5_redir", 32'(redirect_valid), 32'd1);
        check_eq("t5_pcf", upd_pc_fetch, 32'h70);
        drive(1, 0, 32'd0, 0, 0, 32'd0, 2'd0, 1, 1, 1, 32'h300); tick();
        check_eq("t5_pulse_1cyc", 32'(redirect_valid), 32'd0);

        // Random traffic; the 4-bit statistics saturate along the way
        for (int i = 0; i < 800; i++) begin
            rand_drive();
            tick();
        end
        check_eq("t6_bcount_sat", 32'(branch_count), 32'hF);
        check_eq("t6_mcount_sat", 32'(mispredict_count), 32'hF);

        // 6: reset pulled low while a redirect pulse is showing
        begin
            bit found;
            found = 1'b0;
            for (int i = 0; i < 500 && !found; i++) begin
                rand_drive();
                tick();
                found = e_rv;
            end
            check_eq("t6_redir_seen", 32'(found), 32'd1);
        end
        do_reset();
        for (int i = 0; i < 200; i++) begin
            rand_drive();
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
